// File: rtl/status_excl_monitor_if.sv
// Status-flag bus between an FP datapath (master) and the exclusion monitor (slave).
// Carries the sampled flags, the clear strobe and every monitor result.
interface status_excl_monitor_if #(
    parameter int STATUS_W  = 8,
    parameter int NUM_FLAGS = 6,
    parameter int CNT_W     = 16
) ();
    localparam int IDX_W = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;

    logic                 status_valid;
    logic [STATUS_W-1:0]  status;
    logic                 clear;
    logic                 viol_pulse;
    logic [NUM_FLAGS-1:0] viol_flags;
    logic                 sticky_fail;
    logic                 first_valid;
    logic [IDX_W-1:0]     first_i;
    logic [IDX_W-1:0]     first_j;
    logic [CNT_W-1:0]     first_cycle;
    logic [CNT_W-1:0]     viol_count;
    logic [CNT_W-1:0]     sample_count;

    modport master (
        output status_valid, status, clear,
        input  viol_pulse, viol_flags, sticky_fail, first_valid,
        input  first_i, first_j, first_cycle, viol_count, sample_count
    );

    modport slave (
        input  status_valid, status, clear,
        output viol_pulse, viol_flags, sticky_fail, first_valid,
        output first_i, first_j, first_cycle, viol_count, sample_count
    );
endinterface

// File: rtl/status_excl_monitor.sv
// Checks configurable mutually-exclusive status-flag pairs; optional STATUS_EXCL_MONITOR_DISPLAY_EN prints violations.
// Latency: results registered, visible one cycle after the accepted sample.
// Backpressure: none; a valid sample is accepted every cycle, clear discards a coincident sample.
module status_excl_monitor #(
    parameter int STATUS_W  = 8,
    parameter int NUM_FLAGS = 6,
    parameter logic [NUM_FLAGS*NUM_FLAGS-1:0] EXCL_MASK = (NUM_FLAGS*NUM_FLAGS)'(36'h0_0043_8F3E),
    parameter int CNT_W     = 16
) (
    input logic                  i_clk,
    input logic                  i_rst,
    status_excl_monitor_if.slave mon_if
);
    localparam int IDX_W = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {CLEAN, FAILED} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_pulse;
    logic [NUM_FLAGS-1:0] r_flags;
    logic [IDX_W-1:0]     r_fi;
    logic [IDX_W-1:0]     r_fj;
    logic [CNT_W-1:0]     r_fc;
    logic [CNT_W-1:0]     r_vc;
    logic [CNT_W-1:0]     r_sc;

    logic [NUM_FLAGS-1:0] w_flags;
    logic                 w_any;
    logic [IDX_W-1:0]     w_fi;
    logic [IDX_W-1:0]     w_fj;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_sc_inc;
    logic [CNT_W-1:0]     w_vc_inc;

    // Descending scan so the last hit is the lowest i, then lowest j.
    always_comb begin
        w_flags = '0;
        w_fi    = '0;
        w_fj    = '0;
        for (int i = NUM_FLAGS - 2; i >= 0; i--) begin
            for (int j = NUM_FLAGS - 1; j > i; j--) begin
                if (EXCL_MASK[i*NUM_FLAGS+j] && mon_if.status[i] && mon_if.status[j]) begin
                    w_flags[i] = 1'b1;
                    w_flags[j] = 1'b1;
                    w_fi       = IDX_W'(i);
                    w_fj       = IDX_W'(j);
                end
            end
        end
        w_any = |w_flags;
    end

    assign w_accept = mon_if.status_valid && !mon_if.clear;
    assign w_sc_inc = (r_sc == CNT_MAX) ? r_sc : r_sc + 1'b1;
    assign w_vc_inc = (r_vc == CNT_MAX) ? r_vc : r_vc + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (mon_if.clear) begin
            w_state_nxt = CLEAN;
        end else if (w_accept && w_any) begin
            w_state_nxt = FAILED;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLEAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || mon_if.clear) begin
            r_pulse <= 1'b0;
            r_flags <= '0;
            r_fi    <= '0;
            r_fj    <= '0;
            r_fc    <= '0;
            r_vc    <= '0;
            r_sc    <= '0;
        end else if (mon_if.status_valid) begin
            r_pulse <= w_any;
            r_flags <= w_flags;
            r_sc    <= w_sc_inc;
            if (w_any) begin
                r_vc <= w_vc_inc;
            end
            // First-failure fields are frozen once FAILED.
            if (w_any && r_state == CLEAN) begin
                r_fi <= w_fi;
                r_fj <= w_fj;
                r_fc <= r_sc;
            end
        end else begin
            r_pulse <= 1'b0;
            r_flags <= '0;
        end
    end

`ifdef STATUS_EXCL_MONITOR_DISPLAY_EN
    always @(posedge i_clk) begin
        if (!i_rst && w_accept && w_any) begin
            for (int i = 0; i < NUM_FLAGS - 1; i++) begin
                for (int j = i + 1; j < NUM_FLAGS; j++) begin
                    if (EXCL_MASK[i*NUM_FLAGS+j] && mon_if.status[i] && mon_if.status[j]) begin
                        $display("FAIL: flag %0d and flag %0d asserted together (sample_count=%0d)",
                                 i, j, r_sc);
                    end
                end
            end
        end
    end
`endif

    assign mon_if.viol_pulse   = r_pulse;
    assign mon_if.viol_flags   = r_flags;
    assign mon_if.sticky_fail  = (r_state == FAILED);
    assign mon_if.first_valid  = (r_state == FAILED);
    assign mon_if.first_i      = r_fi;
    assign mon_if.first_j      = r_fj;
    assign mon_if.first_cycle  = r_fc;
    assign mon_if.viol_count   = r_vc;
    assign mon_if.sample_count = r_sc;
endmodule

// File: tb/tb_status_excl_monitor.sv
// Scoreboard bench: two monitors (16-bit and 4-bit counters) share stimulus; a pair-rule model predicts every cycle.
module tb_status_excl_monitor;
    logic clk = 1'b0;
    logic t_rst = 1'b1;
    logic t_vld = 1'b0;
    logic [7:0] t_st = 8'h00;
    logic t_clr = 1'b0;

    always #5 clk = ~clk;

    status_excl_monitor_if #(.STATUS_W(8), .NUM_FLAGS(6), .CNT_W(16)) if_a ();
    status_excl_monitor_if #(.STATUS_W(8), .NUM_FLAGS(6), .CNT_W(4))  if_b ();

    assign if_a.status_valid = t_vld;
    assign if_a.status       = t_st;
    assign if_a.clear        = t_clr;
    assign if_b.status_valid = t_vld;
    assign if_b.status       = t_st;
    assign if_b.clear        = t_clr;

    status_excl_monitor #(.STATUS_W(8), .NUM_FLAGS(6), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst(t_rst), .mon_if(if_a.slave));
    status_excl_monitor #(.STATUS_W(8), .NUM_FLAGS(6), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(t_rst), .mon_if(if_b.slave));

    typedef struct packed {
        logic        pulse;
        logic [5:0]  flags;
        logic        sticky;
        logic        fv;
        logic [2:0]  fi;
        logic [2:0]  fj;
        logic [15:0] fc;
        logic [15:0] vc;
        logic [15:0] sc;
    } obs_t;

    obs_t exp_q[2][$];
    int n_vec = 0;
    int n_miss = 0;

    // Reference model state, one slot per monitor instance.
    int cnt_max[2] = '{65535, 15};
    int m_sc[2], m_vc[2], m_fc[2], m_fi[2], m_fj[2];
    bit m_fail[2], m_pulse[2];
    bit [5:0] m_flags[2];

    function automatic bit excl(int i, int j);
        return (i < j) && !((i == 3 && j == 5) || (i == 4 && j == 5));
    endfunction

    function automatic int sat_inc(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model(input bit r, input bit v, input logic [7:0] s, input bit c);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                m_sc[k] = 0; m_vc[k] = 0; m_fc[k] = 0; m_fi[k] = 0; m_fj[k] = 0;
                m_fail[k] = 0; m_pulse[k] = 0; m_flags[k] = 0;
            end else if (v) begin
                bit found;
                int fi, fj;
                bit [5:0] fl;
                found = 0; fi = 0; fj = 0; fl = 0;
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 6; j++)
                        if (excl(i, j) && s[i] && s[j]) begin
                            fl[i] = 1; fl[j] = 1;
                            if (!found) begin found = 1; fi = i; fj = j; end
                        end
                m_pulse[k] = found;
                m_flags[k] = fl;
                if (found) begin
                    m_vc[k] = sat_inc(m_vc[k], cnt_max[k]);
                    if (!m_fail[k]) begin
                        m_fail[k] = 1; m_fi[k] = fi; m_fj[k] = fj; m_fc[k] = m_sc[k];
                    end
                end
                m_sc[k] = sat_inc(m_sc[k], cnt_max[k]);
            end else begin
                m_pulse[k] = 0; m_flags[k] = 0;
            end
            exp_q[k].push_back('{m_pulse[k], m_flags[k], m_fail[k], m_fail[k],
                                 3'(m_fi[k]), 3'(m_fj[k]), 16'(m_fc[k]), 16'(m_vc[k]), 16'(m_sc[k])});
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] s, input bit c);
        t_rst = r; t_vld = v; t_st = s; t_clr = c;
        @(posedge clk);
        model(r, v, s, c);
        #1;
    endtask

    function automatic obs_t observe(input int k);
        if (k == 0)
            return '{if_a.viol_pulse, if_a.viol_flags, if_a.sticky_fail, if_a.first_valid,
                     if_a.first_i, if_a.first_j, if_a.first_cycle, if_a.viol_count, if_a.sample_count};
        else
            return '{if_b.viol_pulse, if_b.viol_flags, if_b.sticky_fail, if_b.first_valid,
                     if_b.first_i, if_b.first_j, 16'(if_b.first_cycle), 16'(if_b.viol_count),
                     16'(if_b.sample_count)};
    endfunction

    // Monitor: one registered observation per clock, popped half a cycle after the edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() > 0) begin
                obs_t e, a;
                e = exp_q[k].pop_front();
                a = observe(k);
                n_vec++;
                if (a !== e) begin
                    n_miss++;
                    $display("FAIL scoreboard dut%0d t=%0t act pulse=%0b flags=%h stk=%0b fv=%0b i=%0d j=%0d fc=%0d vc=%0d sc=%0d req pulse=%0b flags=%h stk=%0b fv=%0b i=%0d j=%0d fc=%0d vc=%0d sc=%0d",
                             k, $time, a.pulse, a.flags, a.sticky, a.fv, a.fi, a.fj, a.fc, a.vc, a.sc,
                             e.pulse, e.flags, e.sticky, e.fv, e.fi, e.fj, e.fc, e.vc, e.sc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    initial begin
        repeat (2) step(1, 0, 8'h00, 0);
        repeat (5) step(0, 0, 8'h00, 0);
        chk("reset_sticky", int'(if_a.sticky_fail), 0);
        chk("reset_samples", int'(if_a.sample_count), 0);

        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'h28, 0);
        step(0, 1, 8'h30, 0);
        chk("allowed_samples", int'(if_a.sample_count), 4);
        chk("allowed_viol", int'(if_a.viol_count), 0);

        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h07, 0);
        chk("first_pulse", int'(if_a.viol_pulse), 1);
        chk("first_flags", int'(if_a.viol_flags), 'h07);
        chk("first_vc", int'(if_a.viol_count), 1);
        chk("first_ij", int'(if_a.first_i) * 8 + int'(if_a.first_j), 1);
        chk("first_cycle", int'(if_a.first_cycle), 2);

        step(0, 1, 8'h18, 0);
        chk("second_flags", int'(if_a.viol_flags), 'h18);
        chk("second_vc", int'(if_a.viol_count), 2);
        chk("frozen_cycle", int'(if_a.first_cycle), 2);

        step(0, 1, 8'h03, 1);
        chk("clear_samples", int'(if_a.sample_count), 0);
        chk("clear_sticky", int'(if_a.sticky_fail), 0);

        repeat (20) step(0, 1, 8'h03, 0);
        chk("sat_samples_b", int'(if_b.sample_count), 15);
        chk("sat_viol_b", int'(if_b.viol_count), 15);
        chk("sat_first_b", int'(if_b.first_cycle), 0);
        chk("nosat_viol_a", int'(if_a.viol_count), 20);

        for (int n = 0; n < 600; n++) begin
            bit r, v, c;
            logic [7:0] s;
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) s = s | 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) s = 8'($urandom);
            step(r, v, s, c);
        end

        step(0, 0, 8'h00, 0);
        repeat (3) @(negedge clk);
        chk("drain_a", exp_q[0].size(), 0);
        chk("drain_b", exp_q[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/status_excl_monitor.md
Name: status_excl_monitor

Overview:
- Parametrised, clocked checker for mutual exclusion between arithmetic status flags (zero, infinity, NaN, tiny, huge, inexact, ...) produced by the FP datapath.
- Generalises the fixed pairwise assertion checker: configurable flag count and exclusion matrix, valid-qualified sampling, registered violation reporting, saturating counters and first-failure capture.
- Instantiated beside the FP unit in testbenches and optionally in silicon debug builds.

Parameters:
- STATUS_W, 8: width of the status bus.
- NUM_FLAGS, 6: number of low status bits checked (status[NUM_FLAGS-1:0]); must be at least 2 and at most STATUS_W.
- EXCL_MASK, default below: NUM_FLAGS*NUM_FLAGS bits; bit (i*NUM_FLAGS+j), for i<j, set means flags i and j must never both be 1. Bits with i>=j are ignored. The default sets every i<j pair in 0..5 except (3,5) and (4,5).
- CNT_W, 16: width of the counters and of first_cycle.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- status_valid, input, 1: status is sampled only when this is 1.
- status, input, STATUS_W: flag bus; bits at NUM_FLAGS and above are ignored.
- clear, input, 1: synchronous clear of all results.
- viol_pulse, output, 1: one-cycle pulse; the previously sampled status violated at least one pair.
- viol_flags, output, NUM_FLAGS: OR of both flags of every violated pair in that sample; valid while viol_pulse=1, 0 otherwise.
- sticky_fail, output, 1: 1 once any violation occurs; held until clear or rst.
- first_valid, output, 1: first-failure fields are valid.
- first_i, output, clog2(NUM_FLAGS): lower flag index of the first violation.
- first_j, output, clog2(NUM_FLAGS): higher flag index of the first violation.
- first_cycle, output, CNT_W: sample index (0-based, value of sample_count) of the first violating sample.
- viol_count, output, CNT_W: number of violating samples; saturates at all-ones.
- sample_count, output, CNT_W: number of accepted samples; saturates at all-ones.

Behaviour:
- Reset: every output is 0; the FSM is in CLEAN. rst has priority over all other inputs.
- Sampling:
  - Cycle N with status_valid=1 and clear=0 accepts the sample.
  - Pair check: violated(i,j) = EXCL_MASK[i*NUM_FLAGS+j] & status[i] & status[j], for i<j.
  - Results are registered: viol_pulse and viol_flags appear in cycle N+1.
  - sample_count and viol_count show their updated values in cycle N+1.
- Each violating sample increments viol_count by exactly 1, however many pairs it violates.
- Saturation: a counter at all-ones stays at all-ones. first_cycle records the sample_count value before the increment; once sample_count has saturated, first_cycle records all-ones.
- FSM states:
  - CLEAN to FAILED on the first violating sample. In that transition, capture first_i/first_j as the violated pair with the lowest i, then the lowest j; capture first_cycle; set first_valid=1 and sticky_fail=1.
  - FAILED stays FAILED on further violations. First-failure fields are frozen; only the counters and pulse outputs update.
  - Either state goes to CLEAN on clear=1 in the next cycle.
- clear:
  - Zeroes the counters, sticky_fail, first_* and viol_pulse in the next cycle.
  - If status_valid=1 in the same cycle as clear, the sample is discarded: not counted, not checked.
- status_valid=0: no update; viol_pulse=0 in the next cycle.
- Back-to-back valid samples are accepted every cycle with no stall.
- Mid-operation rst behaves exactly like reset; any in-flight result is lost.
- NUM_FLAGS=2 degenerates to a single pair check.

Optional Feature:
- Macro STATUS_EXCL_MONITOR_DISPLAY_EN.
- Defined: in the cycle viol_pulse rises, the block prints one "FAIL: flag i and flag j asserted together" line per violated pair, plus sample_count. The block must stay synthesizable with the macro undefined.
- Undefined: no display code is compiled; port behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then idle 5 cycles -> all outputs 0, state CLEAN.
- 4 valid samples status=8'h01, 8'h02, 8'h28, 8'h30 (default mask) -> viol_pulse=0 throughout; sample_count=4; viol_count=0 (pairs (3,5) and (4,5) are permitted).
- Samples 8'h01, 8'h00, then 8'h07 -> in the cycle after the third sample: viol_pulse=1, viol_flags=6'h07, viol_count=1, first_i=0, first_j=1, first_cycle=2, sticky_fail=1.
- Continue with 8'h18 -> viol_count=2, viol_flags=6'h18; first_* unchanged (0,1,2).
- clear=1 together with status_valid=1 and status=8'h03 -> next cycle all counters/fields 0; the sample is not counted; FSM CLEAN.
- CNT_W=4, 20 valid violating samples -> viol_count and sample_count saturate at 4'hF; first_cycle=0.
